flag_xfer_sched: RTL and testbench

- Single-clock (source-domain) scheduler that shares one toggle-based flag synchronizer channel among NREQ requesters.
- Each transfer carries a DW-bit command word. The block arbitrates round-robin, captures the winner's word into a holding register, and issues a one-cycle launch pulse into the synchronizer.
- While the synchronizer reports busy, the holding register is kept stable so the destination domain can sample it on its flag. The requester is acknowledged when busy clears.
- Sits in the clkA domain, directly in front of the synchronizer's in_clkA/busy_clkA pins.

---
 rtl/flag_xfer_sched_pkg.sv | 19 +
 rtl/flag_xfer_sched_rr_arb.sv | 31 +++
 rtl/flag_xfer_sched.sv | 135 +++++++++++++
 tb/tb_flag_xfer_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/flag_xfer_sched_pkg.sv
// Shared types and helpers for the flag transfer scheduler.
package flag_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/flag_xfer_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_hi;
    logic [NREQ-1:0] w_sel;

    // Prefer requests at or above the pointer; fall back to the whole vector on wrap.
    assign w_mask = ~((NREQ'(1) << ptr_i) - NREQ'(1));
    assign w_hi   = req_i & w_mask;
    assign w_sel  = (|w_hi) ? w_hi : req_i;
    assign gnt_o  = w_sel & (~w_sel + NREQ'(1));
    assign vld_o  = |req_i;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_o[i]) idx_o = idx_o | IW'(i);
        end
    end

endmodule

// File: rtl/flag_xfer_sched.sv
// Shares one toggle-flag synchronizer among NREQ requesters: arbitrate, hold the word, launch, await busy.
module flag_xfer_sched import flag_xfer_pkg::*; #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int TMO  = 1023,
    localparam int IW  = (NREQ > 1) ? clog2(NREQ) : 1,
    localparam int CW  = clog2(TMO + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   data_i,
    output logic [NREQ-1:0]      ack_o,
    output logic                 err_o,
    output logic                 flag_o,
    input  logic                 busy_i,
    output logic [DW-1:0]        xfer_data_o,
    output logic [IW-1:0]        xfer_src_o,
    output logic                 active_o,
    output logic                 timeout_o,
    input  logic                 clr_tmo_i
);

    localparam logic [CW-1:0] CMAX = CW'(TMO - 1);

    state_t          r_state;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic            r_flag;
    logic            r_tmo;
    logic [DW-1:0]   r_data;
    logic [IW-1:0]   r_src;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_nxt;
    logic            w_vld;
    logic [DW-1:0]   w_data;
    logic [NREQ-1:0] w_src_oh;

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (r_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .vld_o (w_vld)
    );

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_data = data_i[i*DW +: DW];
        end
    end

    assign w_nxt    = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_src_oh = NREQ'(1) << r_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_flag  <= 1'b0;
            r_tmo   <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_flag <= 1'b0;
            r_ack  <= '0;
            r_err  <= 1'b0;
            if (clr_tmo_i) r_tmo <= 1'b0;
            case (r_state)
                // Busy still high after a timeout blocks the next launch.
                IDLE: begin
                    if (w_vld && !busy_i) begin
                        r_data  <= w_data;
                        r_src   <= w_idx;
                        r_ptr   <= w_nxt;
                        r_flag  <= 1'b1;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy_i) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CMAX) begin
                        r_ack   <= w_src_oh;
                        r_err   <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy_i) begin
                        r_ack   <= w_src_oh;
                        r_state <= DONE;
                    end else if (r_cnt == CMAX) begin
                        r_ack   <= w_src_oh;
                        r_err   <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack_o       = r_ack;
    assign err_o       = r_err;
    assign flag_o      = r_flag;
    assign xfer_data_o = r_data;
    assign xfer_src_o  = r_src;
    assign active_o    = (r_state != IDLE);
    assign timeout_o   = r_tmo;

endmodule

// File: tb/tb_flag_xfer_sched.sv
// Randomized self-checking bench for flag_xfer_sched against a transaction-level timing model.
module tb_flag_xfer_sched;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int TMO  = 15;
    localparam int M_NORM  = 0;
    localparam int M_STUCK = 1;
    localparam int M_NEVER = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [63:0] data_i;
    logic [3:0]  ack_o;
    logic        err_o;
    logic        flag_o;
    logic        busy_i;
    logic [15:0] xfer_data_o;
    logic [1:0]  xfer_src_o;
    logic        active_o;
    logic        timeout_o;
    logic        clr_tmo_i;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;
    bit m_tmo = 1'b0;

    always #5 clk = ~clk;

    flag_xfer_sched #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .flag_o      (flag_o),
        .busy_i      (busy_i),
        .xfer_data_o (xfer_data_o),
        .xfer_src_o  (xfer_src_o),
        .active_o    (active_o),
        .timeout_o   (timeout_o),
        .clr_tmo_i   (clr_tmo_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_flag"}, flag_o, 0);
        chk({tag, "_ack"}, ack_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_active"}, active_o, 0);
        chk({tag, "_data"}, xfer_data_o, 0);
        chk({tag, "_src"}, xfer_src_o, 0);
        chk({tag, "_tmo"}, timeout_o, 0);
    endtask

    // Entered #1 after a clock edge with the DUT idle; the next edge is the grant edge.
    task automatic do_xfer(input logic [3:0] reqv, input logic [63:0] dat, input int mode,
                           input int dur, input int rst_at, input bit clr_same);
        int g;
        int off;
        logic [15:0] exp_d;
        g = rr_pick(reqv);
        exp_d = dat[g*16 +: 16];
        m_ptr = (g + 1) % NREQ;
        req_i  = reqv;
        data_i = dat;
        @(posedge clk); #1;
        chk("launch_flag", flag_o, 1);
        chk("grant_src", xfer_src_o, g);
        chk("grant_data", xfer_data_o, exp_d);
        chk("launch_active", active_o, 1);
        chk("launch_ack", ack_o, 0);
        off = (mode == M_NORM) ? dur + 2 : (mode == M_STUCK) ? TMO + 2 : TMO + 1;
        for (int c = 1; c <= off; c++) begin
            @(posedge clk); #1;
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("async_rst");
                m_ptr = 0; m_tmo = 1'b0;
                req_i = '0; busy_i = 1'b0; clr_tmo_i = 1'b0;
                @(posedge clk); #1;
                chk("rst_no_ack", ack_o, 0);
                chk("rst_inactive", active_o, 0);
                rst_n = 1'b1;
                return;
            end
            if (c == off) begin
                if (mode != M_NORM) m_tmo = 1'b1;
                chk("done_ack", ack_o, 64'(1) << g);
                chk("done_err", err_o, (mode != M_NORM));
                chk("done_tmo", timeout_o, m_tmo);
                clr_tmo_i = 1'b0;
            end else begin
                chk("wait_ack", ack_o, 0);
                chk("wait_flag", flag_o, 0);
                chk("hold_data", xfer_data_o, exp_d);
                chk("hold_src", xfer_src_o, g);
                chk("wait_active", active_o, 1);
                data_i[g*16 +: 16] = 16'($urandom);
            end
            if (mode == M_NORM) busy_i = (c <= dur);
            else if (mode == M_STUCK) busy_i = 1'b1;
            if (clr_same && c == off - 1) clr_tmo_i = 1'b1;
        end
        req_i[g] = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack", ack_o, 0);
        chk("idle_err", err_o, 0);
        chk("idle_active", active_o, 0);
        chk("idle_flag", flag_o, 0);
        chk("idle_tmo", timeout_o, m_tmo);
        chk("idle_hold", xfer_data_o, exp_d);
        if (mode == M_STUCK) begin
            req_i = 4'b1111;
            for (int w = 0; w < 3; w++) begin
                @(posedge clk); #1;
                chk("busy_block_flag", flag_o, 0);
                chk("busy_block_active", active_o, 0);
            end
            clr_tmo_i = 1'b1;
            @(posedge clk); #1;
            clr_tmo_i = 1'b0;
            m_tmo = 1'b0;
            chk("tmo_clear", timeout_o, 0);
            chk("busy_block_flag2", flag_o, 0);
            busy_i = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_i = '0; data_i = '0; busy_i = 1'b0; clr_tmo_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;

        // Round-robin with all four requesting: 0,1,2,3,0
        for (int t = 0; t < 5; t++)
            do_xfer(4'b1111, {$urandom, $urandom}, M_NORM, $urandom_range(1, 6), 0, 1'b0);

        do_xfer(4'b0010, {16'h1111, 16'h2222, 16'hBEEF, 16'h4444}, M_NORM, 5, 0, 1'b0);
        do_xfer(4'($urandom_range(1, 15)), {$urandom, $urandom}, M_STUCK, 0, 0, 1'b0);
        do_xfer(4'($urandom_range(1, 15)), {$urandom, $urandom}, M_NEVER, 0, 0, 1'b1);
        req_i = '0;
        clr_tmo_i = 1'b1;
        @(posedge clk); #1;
        clr_tmo_i = 1'b0;
        m_tmo = 1'b0;
        chk("tmo_clear2", timeout_o, 0);

        for (int t = 0; t < 20; t++)
            do_xfer(4'($urandom_range(1, 15)), {$urandom, $urandom}, M_NORM,
                    $urandom_range(1, 8), 0, 1'b0);

        // Leave the pointer non-zero, then reset in WAIT_DONE; pointer must restart at 0.
        do_xfer(4'b0010, {$urandom, $urandom}, M_NORM, 6, 4, 1'b0);
        do_xfer(4'b1111, {$urandom, $urandom}, M_NORM, 3, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
